carpool_inj_ctrl: RTL



---
 rtl/carpool_inj_ctrl_pkg.sv | 15 +
 rtl/carpool_match_pe.sv | 48 ++++
 rtl/carpool_inj_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/carpool_inj_ctrl_pkg.sv
// Shared types and router-wide field widths for the carpool injection controller.
package carpool_inj_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        INJECT = 2'd2
    } state_t;

    localparam int SRC_LIST_WIDTH = 16;
    localparam int MEM_ADDR_WIDTH = 8;
    localparam int DST_WIDTH      = 16;
    localparam int NUM_FLIT_WIDTH = 2;

endpackage

// File: rtl/carpool_match_pe.sv
// Parallel comparison of the pending flit against every network input port,
// followed by a lowest-index priority pick.
module carpool_match_pe
    import carpool_inj_ctrl_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int ADDR_W = MEM_ADDR_WIDTH,
    parameter int DST_W  = DST_WIDTH,
    parameter int FID_W  = NUM_FLIT_WIDTH
) (
    input  logic [NUM_IN-1:0]        net_hs,
    input  logic [NUM_IN*ADDR_W-1:0] net_addr,
    input  logic [NUM_IN*DST_W-1:0]  net_dst,
    input  logic [NUM_IN*FID_W-1:0]  net_flitID,
    input  logic [ADDR_W-1:0]        pend_addr,
    input  logic [DST_W-1:0]         pend_dst,
    input  logic [FID_W-1:0]         pend_flitID,
    output logic                     match_any,
    output logic [NUM_IN-1:0]        match_onehot
);

    logic [NUM_IN-1:0] match;
    logic              found;

    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            match[i] = net_hs[i]
                    && (net_addr[i*ADDR_W +: ADDR_W] == pend_addr)
                    && (net_dst[i*DST_W +: DST_W] == pend_dst)
                    && (net_flitID[i*FID_W +: FID_W] == pend_flitID);
        end
    end

    always_comb begin
        match_onehot = '0;
        found        = 1'b0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (match[i] && !found) begin
                match_onehot[i] = 1'b1;
                found           = 1'b1;
            end
        end
    end

    assign match_any = |match;

endmodule

// File: rtl/carpool_inj_ctrl.sv
// Local-port injection scheduler: holds a multicast flit briefly so it can
// piggyback on a matching in-flight flit, otherwise injects it.
module carpool_inj_ctrl
    import carpool_inj_ctrl_pkg::*;
#(
    parameter int NUM_IN   = 4,
    parameter int SRC_W    = SRC_LIST_WIDTH,
    parameter int ADDR_W   = MEM_ADDR_WIDTH,
    parameter int DST_W    = DST_WIDTH,
    parameter int FID_W    = NUM_FLIT_WIDTH,
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inj_valid,
    input  logic                     inj_mc,
    input  logic [SRC_W-1:0]         inj_srcList,
    input  logic [ADDR_W-1:0]        inj_addr,
    input  logic [DST_W-1:0]         inj_dst,
    input  logic [FID_W-1:0]         inj_flitID,
    output logic                     inj_ready,
    input  logic [NUM_IN-1:0]        net_hs,
    input  logic [NUM_IN*ADDR_W-1:0] net_addr,
    input  logic [NUM_IN*DST_W-1:0]  net_dst,
    input  logic [NUM_IN*FID_W-1:0]  net_flitID,
    output logic                     merge_en,
    output logic [NUM_IN-1:0]        merge_port,
    output logic [SRC_W-1:0]         merge_srcList,
    output logic                     out_valid,
    output logic [SRC_W-1:0]         out_srcList,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DST_W-1:0]         out_dst,
    output logic [FID_W-1:0]         out_flitID,
    output logic                     done,
    output logic [CNT_W-1:0]         merge_cnt,
    output logic [CNT_W-1:0]         timeout_cnt
);

    localparam int WCNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = (HOLD_MAX > 0) ? WCNT_W'(HOLD_MAX - 1) : '0;

    state_t              state, next_state;
    logic [SRC_W-1:0]    pend_srcList;
    logic [ADDR_W-1:0]   pend_addr;
    logic [DST_W-1:0]    pend_dst;
    logic [FID_W-1:0]    pend_flitID;
    logic [WCNT_W-1:0]   wait_cnt;
    logic                match_any;
    logic [NUM_IN-1:0]   match_onehot;
    logic                slot_free;
    logic                wait_last;

    carpool_match_pe #(
        .NUM_IN (NUM_IN),
        .ADDR_W (ADDR_W),
        .DST_W  (DST_W),
        .FID_W  (FID_W)
    ) u_match_pe (
        .net_hs       (net_hs),
        .net_addr     (net_addr),
        .net_dst      (net_dst),
        .net_flitID   (net_flitID),
        .pend_addr    (pend_addr),
        .pend_dst     (pend_dst),
        .pend_flitID  (pend_flitID),
        .match_any    (match_any),
        .match_onehot (match_onehot)
    );

    assign slot_free = ~&net_hs;
    assign wait_last = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (inj_valid) begin
                    next_state = (inj_mc && (HOLD_MAX > 0)) ? WAIT : INJECT;
                end
            end
            WAIT: begin
                if (match_any) begin
                    next_state = IDLE;
                end else if (wait_last) begin
                    next_state = INJECT;
                end
            end
            INJECT: begin
                if (slot_free) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        inj_ready     = 1'b0;
        merge_en      = 1'b0;
        merge_port    = '0;
        merge_srcList = '0;
        out_valid     = 1'b0;
        out_srcList   = '0;
        out_addr      = '0;
        out_dst       = '0;
        out_flitID    = '0;
        done          = 1'b0;
        case (state)
            IDLE: inj_ready = 1'b1;
            WAIT: begin
                if (match_any) begin
                    merge_en      = 1'b1;
                    merge_port    = match_onehot;
                    merge_srcList = pend_srcList;
                    done          = 1'b1;
                end
            end
            INJECT: begin
                out_valid   = 1'b1;
                out_srcList = pend_srcList;
                out_addr    = pend_addr;
                out_dst     = pend_dst;
                out_flitID  = pend_flitID;
                done        = slot_free;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_srcList <= '0;
            pend_addr    <= '0;
            pend_dst     <= '0;
            pend_flitID  <= '0;
            wait_cnt     <= '0;
            merge_cnt    <= '0;
            timeout_cnt  <= '0;
        end else begin
            if (state == IDLE && inj_valid) begin
                pend_srcList <= inj_srcList;
                pend_addr    <= inj_addr;
                pend_dst     <= inj_dst;
                pend_flitID  <= inj_flitID;
                wait_cnt     <= '0;
            end
            // A match in the final compare cycle takes precedence over the timeout.
            if (state == WAIT) begin
                if (match_any) begin
                    if (merge_cnt != '1) merge_cnt <= merge_cnt + CNT_W'(1);
                end else if (wait_last) begin
                    if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + CNT_W'(1);
                end else begin
                    wait_cnt <= wait_cnt + WCNT_W'(1);
                end
            end
        end
    end

endmodule
